load_store_memory: RTL and testbench
====================================

// Module: load_store_memory
// PURPOSE
//  Parametrised data memory that adds RV32I sub-word loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW),
//  a valid/ready request handshake, configurable access latency and error reporting. It sits
//  between the CPU datapath (address = ALU result, wdata = rs2) and the register write-back mux.
//  It is the multi-cycle successor of the single-cycle word-only data memory.
// PARAMETERS
//  DEPTH    32  number of 32-bit words (>=1)
//  LATENCY  1   cycles from accept edge to response (>=1; LATENCY<1 is an elaboration error)
// PORTS
//  clk             in   1          clock, all state updates on posedge
//  reset           in   1          synchronous, active-high
//  req_valid       in   1          request present
//  req_ready       out  1          block can accept a request this cycle
//  req_write       in   1          1 = store, 0 = load
//  req_funct3      in   3          RV32I funct3 of the load/store
//  req_address     in   32         byte address
//  req_wdata       in   32         store data (low bits used for SB/SH)
//  resp_valid      out  1          one-cycle response pulse
//  resp_rdata      out  32         load result, extended to 32 bits; 0 for stores/errors
//  resp_error      out  1          request rejected (misaligned / bad funct3 / out of range)
//  initial_values  in   32 x DEPTH loaded into the array on every reset cycle
//  memory_check    out  32 x DEPTH combinational view of the array
// BEHAVIOUR
//  - Reset: state=IDLE, resp_valid=0, resp_rdata=0, resp_error=0, mem[i]<=initial_values[i];
//    req_ready=0 while reset is high. Reset mid-operation aborts: no write, no response.
//  - FSM IDLE -> BUSY -> RESP -> IDLE. req_ready = (state==IDLE) && !reset.
//  - IDLE: on req_valid, latch request at the edge, cnt<=LATENCY-1, go BUSY.
//  - BUSY: cnt!=0 -> cnt-1. cnt==0 -> at this edge perform access, register resp_*, go RESP.
//  - RESP: resp_valid=1 for exactly one cycle (no backpressure), then IDLE.
//  - Timing: accept at edge E -> resp_valid high in the cycle after edge E+LATENCY;
//    next accept at earliest edge E+LATENCY+2. One outstanding request only.
//  - Word index = address[31:2]; byte lanes little-endian (lane n = bits 8n+7:8n).
//  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; LB/LH sign-extend, LBU/LHU zero-extend.
//  - Stores: 000 SB writes lane address[1:0]; 001 SH writes lanes {addr[1],0} pair; 010 SW all.
//    Unwritten lanes unchanged. Store response: resp_rdata=0, resp_error=0.
//  - Error (resp_error=1, resp_rdata=0, array untouched): halfword with address[0]=1; word with
//    address[1:0]!=0; load funct3 in {011,110,111}; store funct3 >= 011; word index >= DEPTH
//    (no wrap-around).
//  - Request inputs are ignored outside IDLE; changing them after accept has no effect.
//  - memory_check reflects array contents; a store is visible in the RESP cycle.
// TESTING
//  1. Reset with initial_values[1]=32'h8081_F2F3, LATENCY=1: req_ready=0 in reset, 1 after;
//     LW addr 4 accepted edge E -> resp_valid only in cycle after E+1, rdata 32'h8081_F2F3.
//  2. Sub-word loads of word 1: LB addr 4 -> 32'hFFFF_FFF3; LBU addr 7 -> 32'h0000_0080;
//     LH addr 6 -> 32'hFFFF_8081; LHU addr 4 -> 32'h0000_F2F3.
//  3. Stores: SB addr 9 wdata 32'h0000_00AB on word 2 = 0 -> memory_check[2]=32'h0000_AB00;
//     then SH addr 10 wdata 32'h1234 -> 32'h1234_AB00; SW addr 8 wdata 1 -> 32'h0000_0001.
//  4. Errors: LW addr 2, SH addr 5, load funct3 3'b111, SW addr 4*DEPTH -> each resp_error=1,
//     resp_rdata=0, memory_check unchanged.
//  5. LATENCY=4: req_valid held high continuously -> accepts spaced exactly 6 cycles,
//     resp_valid a single-cycle pulse 4 edges after each accept.
//  6. Assert reset while BUSY on SW addr 0 wdata 32'hDEAD_BEEF -> no resp_valid, mem[0]
//     = initial_values[0], req_ready=1 first cycle after reset drops.

Source files
------------

// File: rtl/load_store_memory.sv
// RV32I data memory with sub-word loads/stores, valid/ready request handshake,
// fixed configurable access latency and error reporting for illegal accesses.
module load_store_memory #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_address,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_error,
  input  logic [32*DEPTH-1:0]    initial_values,
  output logic [32*DEPTH-1:0]    memory_check
);

  if (LATENCY < 1) begin : g_latency_check
    $error("load_store_memory: LATENCY must be >= 1");
  end

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            r_write;
  logic [2:0]      r_funct3;
  logic [31:0]     r_addr, r_wdata;
  logic [31:0]     mem [DEPTH];

  logic            access;
  logic            bad;
  logic [3:0]      lane_en;
  logic [AW-1:0]   idx;
  logic [31:0]     word, shifted, load_val, wrep, store_word;

  assign idx     = r_addr[AW+1:2];
  assign word    = mem[idx];
  assign access  = (state == BUSY) && (cnt == '0);
  assign shifted = word >> {r_addr[1:0], 3'b000};

  // Decode legality and written lanes from the latched request.
  always_comb begin
    bad     = 1'b0;
    lane_en = 4'b0000;
    if (r_write) begin
      case (r_funct3)
        3'b000:  lane_en = 4'b0001 << r_addr[1:0];
        3'b001: begin
          bad     = r_addr[0];
          lane_en = r_addr[1] ? 4'b1100 : 4'b0011;
        end
        3'b010: begin
          bad     = |r_addr[1:0];
          lane_en = 4'b1111;
        end
        default: bad = 1'b1;
      endcase
    end else begin
      case (r_funct3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = r_addr[0];
        3'b010:         bad = |r_addr[1:0];
        default:        bad = 1'b1;
      endcase
    end
    if ({2'b00, r_addr[31:2]} >= 32'(DEPTH)) bad = 1'b1;
  end

  always_comb begin
    load_val = word;
    case (r_funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: load_val = word;
    endcase
  end

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   wrep = {4{r_wdata[7:0]}};
      2'b01:   wrep = {2{r_wdata[15:0]}};
      default: wrep = r_wdata;
    endcase
    for (int n = 0; n < 4; n++) begin
      store_word[8*n +: 8] = lane_en[n] ? wrep[8*n +: 8] : word[8*n +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      r_write    <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        r_write  <= req_write;
        r_funct3 <= req_funct3;
        r_addr   <= req_address;
        r_wdata  <= req_wdata;
        cnt      <= CW'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        resp_rdata <= (bad || r_write) ? 32'b0 : load_val;
        resp_error <= bad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= initial_values[32*i +: 32];
    end else if (access && r_write && !bad) begin
      mem[idx] <= store_word;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && !reset;
    resp_valid = (state == RESP);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) memory_check[32*i +: 32] = mem[i];
  end

endmodule

// File: tb/tb_load_store_memory.sv
// Randomized bench for load_store_memory against a byte-level reference model;
// a second instance with LATENCY=4 covers back-to-back handshake spacing.
module tb_load_store_memory;
  localparam int DEPTH = 32;
  localparam int LAT   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                req_valid, req_ready, req_write;
  logic [2:0]          req_funct3;
  logic [31:0]         req_address, req_wdata;
  logic                resp_valid, resp_error;
  logic [31:0]         resp_rdata;
  logic [32*DEPTH-1:0] initial_values, memory_check;

  logic                l4_valid, l4_ready, l4_resp_valid, l4_resp_error;
  logic [31:0]         l4_resp_rdata;
  logic [32*DEPTH-1:0] l4_memory_check;

  load_store_memory #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .initial_values(initial_values), .memory_check(memory_check)
  );

  load_store_memory #(.DEPTH(DEPTH), .LATENCY(4)) dut_l4 (
    .clk(clk), .reset(reset),
    .req_valid(l4_valid), .req_ready(l4_ready), .req_write(1'b0),
    .req_funct3(3'b010), .req_address(32'd4), .req_wdata(32'd0),
    .resp_valid(l4_resp_valid), .resp_rdata(l4_resp_rdata), .resp_error(l4_resp_error),
    .initial_values(initial_values), .memory_check(l4_memory_check)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [31:0] ref_mem [DEPTH];

  // Reference: size/sign from funct3, alignment by modulo, lanes as byte slices.
  function automatic void model(input bit w, input bit [2:0] f, input bit [31:0] a,
                                input bit [31:0] wd, output bit [31:0] rd, output bit er);
    int sz;
    bit sgn;
    bit [31:0] v, mask;
    int unsigned off, widx;
    sz = 0; sgn = 0; rd = 0; er = 0;
    off = a % 4;
    widx = a / 4;
    if (w) begin
      case (f)
        3'd0: sz = 1;
        3'd1: sz = 2;
        3'd2: sz = 4;
        default: er = 1;
      endcase
    end else begin
      case (f)
        3'd0: begin sz = 1; sgn = 1; end
        3'd1: begin sz = 2; sgn = 1; end
        3'd2: sz = 4;
        3'd4: sz = 1;
        3'd5: sz = 2;
        default: er = 1;
      endcase
    end
    if (!er && (off % sz) != 0) er = 1;
    if (widx >= DEPTH) er = 1;
    if (er) return;
    if (w) begin
      for (int b = 0; b < sz; b++) ref_mem[widx][8*(off+b) +: 8] = wd[8*b +: 8];
    end else begin
      v = ref_mem[widx] >> (8*off);
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 1);
      v = v & mask;
      if (sgn && v[8*sz-1]) v = v | ~mask;
      rd = v;
    end
  endfunction

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s mem[%0d]", tag, i), memory_check[32*i +: 32], ref_mem[i]);
  endtask

  task automatic do_req(input bit w, input bit [2:0] f, input bit [31:0] a, input bit [31:0] wd,
                        output logic [31:0] rd, output logic er);
    bit [31:0] exp_rd;
    bit exp_er;
    int k;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_no_resp", 32'(resp_valid), 32'd0);
    req_valid = 1; req_write = w; req_funct3 = f; req_address = a; req_wdata = wd;
    model(w, f, a, wd, exp_rd, exp_er);
    @(posedge clk);
    #1;
    req_valid = 0;
    req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_address = $urandom; req_wdata = $urandom;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      k++;
      if (resp_valid) break;
    end
    check("latency", 32'(k), 32'(LAT + 1));
    rd = resp_rdata;
    er = resp_error;
    check("rdata", rd, exp_rd);
    check("error", 32'(er), 32'(exp_er));
    check_mem("after_req");
  endtask

  logic [31:0] rd;
  logic        er;
  int          acc_q[$];
  int          rsp_q[$];
  logic        prev_rv;

  initial begin
    reset = 1; req_valid = 0; req_write = 0; req_funct3 = 0;
    req_address = 0; req_wdata = 0; l4_valid = 0;
    for (int i = 0; i < DEPTH; i++) initial_values[32*i +: 32] = $urandom;
    initial_values[32*1 +: 32] = 32'h8081_F2F3;
    initial_values[32*2 +: 32] = 32'h0000_0000;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = initial_values[32*i +: 32];

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_l4_ready", 32'(l4_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_error", 32'(resp_error), 32'd0);
    check_mem("reset");
    reset = 0;

    do_req(0, 3'b010, 32'd4, 0, rd, er);
    check("t1_lw", rd, 32'h8081_F2F3);

    do_req(0, 3'b000, 32'd4, 0, rd, er);  check("t2_lb",  rd, 32'hFFFF_FFF3);
    do_req(0, 3'b100, 32'd7, 0, rd, er);  check("t2_lbu", rd, 32'h0000_0080);
    do_req(0, 3'b001, 32'd6, 0, rd, er);  check("t2_lh",  rd, 32'hFFFF_8081);
    do_req(0, 3'b101, 32'd4, 0, rd, er);  check("t2_lhu", rd, 32'h0000_F2F3);

    do_req(1, 3'b000, 32'd9, 32'h0000_00AB, rd, er);
    check("t3_sb", memory_check[64 +: 32], 32'h0000_AB00);
    check("t3_sb_rdata", rd, 32'd0);
    do_req(1, 3'b001, 32'd10, 32'h0000_1234, rd, er);
    check("t3_sh", memory_check[64 +: 32], 32'h1234_AB00);
    do_req(1, 3'b010, 32'd8, 32'h0000_0001, rd, er);
    check("t3_sw", memory_check[64 +: 32], 32'h0000_0001);

    do_req(0, 3'b010, 32'd2, 0, rd, er);
    check("t4_lw_mis_err", 32'(er), 32'd1);  check("t4_lw_mis_rd", rd, 32'd0);
    do_req(1, 3'b001, 32'd5, 32'hFFFF_FFFF, rd, er);
    check("t4_sh_mis_err", 32'(er), 32'd1);  check("t4_sh_mis_rd", rd, 32'd0);
    do_req(0, 3'b111, 32'd0, 0, rd, er);
    check("t4_f3_err", 32'(er), 32'd1);      check("t4_f3_rd", rd, 32'd0);
    do_req(1, 3'b010, 32'(4*DEPTH), 32'h5555_5555, rd, er);
    check("t4_oor_err", 32'(er), 32'd1);     check("t4_oor_rd", rd, 32'd0);

    for (int t = 0; t < 80; t++) begin
      bit [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 7));
      do_req(1'($urandom), 3'($urandom), a, $urandom, rd, er);
    end

    // Continuous request on the LATENCY=4 instance.
    @(negedge clk);
    l4_valid = 1;
    prev_rv = 0;
    for (int c = 0; c < 40; c++) begin
      if (l4_ready && l4_valid) acc_q.push_back(cyc + 1);
      if (l4_resp_valid) begin
        rsp_q.push_back(cyc);
        check("l4_rdata", l4_resp_rdata, initial_values[32 +: 32]);
        check("l4_error", 32'(l4_resp_error), 32'd0);
        if (prev_rv) check("l4_pulse_width", 32'd2, 32'd1);
      end
      prev_rv = l4_resp_valid;
      @(negedge clk);
    end
    l4_valid = 0;
    check("l4_accept_count", 32'(acc_q.size() >= 5), 32'd1);
    check("l4_resp_count", 32'(rsp_q.size() >= acc_q.size() - 1), 32'd1);
    for (int i = 1; i < acc_q.size(); i++)
      check("l4_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd6);
    for (int i = 0; i < rsp_q.size() && i < acc_q.size(); i++)
      check("l4_resp_edge", 32'(rsp_q[i]), 32'(acc_q[i] + 4));

    // Reset while BUSY aborts the store.
    repeat (3) @(negedge clk);
    check("t6_ready", 32'(req_ready), 32'd1);
    req_valid = 1; req_write = 1; req_funct3 = 3'b010;
    req_address = 32'd0; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("t6_no_resp", 32'(resp_valid), 32'd0);
    check("t6_ready_in_reset", 32'(req_ready), 32'd0);
    reset = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = initial_values[32*i +: 32];
    @(negedge clk);
    check("t6_ready_after", 32'(req_ready), 32'd1);
    check("t6_no_resp_after", 32'(resp_valid), 32'd0);
    check("t6_mem0", memory_check[0 +: 32], initial_values[0 +: 32]);
    check_mem("t6");
    do_req(0, 3'b010, 32'd4, 0, rd, er);
    check("t6_lw_after", rd, 32'h8081_F2F3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
